// File: rtl/ser_tx_nb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ser_tx_nb_pkg
// Description : Shared constants for the ser_tx_nb serialiser: FSM state
//               codes and universal shift register select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_tx_nb_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] sel_t;

    // FSM state encoding
    localparam state_t c_st_idle  = 2'b00;
    localparam state_t c_st_shift = 2'b01;
    localparam state_t c_st_done  = 2'b10;

    // Universal shift register select codes
    localparam sel_t c_sel_hold = 2'b00;
    localparam sel_t c_sel_load = 2'b01;
    localparam sel_t c_sel_shl  = 2'b10;
    localparam sel_t c_sel_shr  = 2'b11;

endpackage : ser_tx_nb_pkg
`default_nettype wire

// File: rtl/ser_tx_nb_if.sv
`default_nettype none
// ============================================================================
// Module      : ser_tx_nb_if
// Description : Word handshake and serial output bundle of ser_tx_nb.
//               master = word source / serial sink, slave = the serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
interface ser_tx_nb_if #(
    parameter int n = 8
);
    logic [n-1:0] data_in;
    logic         valid;
    logic         ready;
    logic         sout;
    logic         sout_vld;
    logic         busy;
    logic         done;

    modport master (
        output data_in, valid,
        input  ready, sout, sout_vld, busy, done
    );

    modport slave (
        input  data_in, valid,
        output ready, sout, sout_vld, busy, done
    );
endinterface : ser_tx_nb_if
`default_nettype wire

// File: rtl/ser_tx_nb_usr_nb.sv
`default_nettype none
// ============================================================================
// Module      : usr_nb
// Description : N-bit universal shift register: hold, parallel load,
//               shift left or shift right with a serial fill bit.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_nb
    import ser_tx_nb_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic         clk,
    input  wire logic         clr,
    input  wire sel_t         i_sel,
    input  wire logic         i_dbit,
    input  wire logic [N-1:0] i_d,
    output logic      [N-1:0] o_q
);

    logic [N-1:0] r_q;

    // Register update selected by i_sel; async clear empties the register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q <= '0;
        end else begin
            case (i_sel)
                c_sel_load: r_q <= i_d;
                c_sel_shl:  r_q <= {r_q[N-2:0], i_dbit};
                c_sel_shr:  r_q <= {i_dbit, r_q[N-1:1]};
                default:    r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule : usr_nb
`default_nettype wire

// File: rtl/ser_tx_nb.sv
`default_nettype none
// ============================================================================
// Module      : ser_tx_nb
// Description : Parallel-to-serial transmitter with valid/ready word intake.
//               Each bit is held for CPB clocks; a one-cycle done pulse
//               closes every frame. Outputs decode registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_tx_nb
    import ser_tx_nb_pkg::*;
#(
    parameter int n         = 8,
    parameter int CPB       = 1,
    parameter int MSB_FIRST = 1
) (
    input  wire logic   clk,
    input  wire logic   clr,
    ser_tx_nb_if.slave  bus
);

    localparam int c_bw = $clog2(n + 1);
    localparam int c_cw = $clog2(CPB + 1);

    localparam logic [c_bw-1:0] c_last_bit = c_bw'(n - 1);
    localparam logic [c_bw-1:0] c_bit_one  = c_bw'(1);
    localparam logic [c_cw-1:0] c_last_clk = c_cw'(CPB - 1);
    localparam logic [c_cw-1:0] c_clk_one  = c_cw'(1);

    // Shift direction moves the register toward the output end
    localparam sel_t c_sel_out = (MSB_FIRST != 0) ? c_sel_shl : c_sel_shr;

    state_t          r_state;
    logic [c_bw-1:0] r_bit_cnt;
    logic [c_cw-1:0] r_clk_cnt;
    logic [n-1:0]    w_q;
    sel_t            w_sel;
    logic            w_handshake;
    logic            w_bit_end;
    logic            w_last_bit;

    assign w_handshake = (r_state == c_st_idle) && bus.valid;
    assign w_bit_end   = (r_state == c_st_shift) && (r_clk_cnt == c_last_clk);
    assign w_last_bit  = (r_bit_cnt == c_last_bit);

    // Shift register command: load on handshake, shift on interior bit ends.
    // The final bit end moves to DONE without shifting.
    always_comb begin
        w_sel = c_sel_hold;
        if (w_handshake) begin
            w_sel = c_sel_load;
        end else if (w_bit_end && !w_last_bit) begin
            w_sel = c_sel_out;
        end
    end

    // FSM and bit/clock counters
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.valid) begin
                        r_state   <= c_st_shift;
                        r_bit_cnt <= '0;
                        r_clk_cnt <= '0;
                    end
                end
                c_st_shift: begin
                    if (r_clk_cnt == c_last_clk) begin
                        r_clk_cnt <= '0;
                        if (w_last_bit) begin
                            r_state <= c_st_done;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_bit_one;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_clk_one;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    usr_nb #(
        .N (n)
    ) u_usr (
        .clk    (clk),
        .clr    (clr),
        .i_sel  (w_sel),
        .i_dbit (1'b0),
        .i_d    (bus.data_in),
        .o_q    (w_q)
    );

    // Output decode from registered state and register contents only
    assign bus.ready    = (r_state == c_st_idle);
    assign bus.busy     = (r_state == c_st_shift) || (r_state == c_st_done);
    assign bus.sout_vld = (r_state == c_st_shift);
    assign bus.done     = (r_state == c_st_done);
    assign bus.sout     = (r_state == c_st_shift) &&
                          ((MSB_FIRST != 0) ? w_q[n-1] : w_q[0]);

endmodule : ser_tx_nb
`default_nettype wire

// File: tb/tb_ser_tx_nb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ser_tx_nb
// Description : Directed self-checking bench for ser_tx_nb. Instance A is
//               n=8/CPB=1/MSB first, instance B is n=8/CPB=3/LSB first.
//               Status vector order: {sout_vld, busy, ready, done, sout}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_tx_nb;

    logic clk;
    logic clr_a;
    logic clr_b;
    logic cur;          // 0 selects instance A, 1 selects instance B
    int   n_checks;
    int   n_errors;

    ser_tx_nb_if #(.n(8)) ifa ();
    ser_tx_nb_if #(.n(8)) ifb ();

    ser_tx_nb #(.n(8), .CPB(1), .MSB_FIRST(1)) dut_a (
        .clk (clk),
        .clr (clr_a),
        .bus (ifa)
    );

    ser_tx_nb #(.n(8), .CPB(3), .MSB_FIRST(0)) dut_b (
        .clk (clk),
        .clr (clr_b),
        .bus (ifb)
    );

    logic [4:0] w_st_a;
    logic [4:0] w_st_b;
    logic [4:0] w_st;
    assign w_st_a = {ifa.sout_vld, ifa.busy, ifa.ready, ifa.done, ifa.sout};
    assign w_st_b = {ifb.sout_vld, ifb.busy, ifb.ready, ifb.done, ifb.sout};
    assign w_st   = cur ? w_st_b : w_st_a;

    localparam logic [4:0] c_idle = 5'b00100;
    localparam logic [4:0] c_done = 5'b01010;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d);
        if (cur) begin
            ifb.valid   = v;
            ifb.data_in = d;
        end else begin
            ifa.valid   = v;
            ifa.data_in = d;
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 200; k++) begin
            if (w_st[2]) break;
            @(negedge clk);
        end
        check("wait_ready", {31'd0, w_st[2]}, 32'd1);
    endtask

    // One complete frame; entered and left on a falling edge with the DUT idle
    task automatic frame(input logic [7:0] w, input int cpb, input bit msb,
                         input bit rnd, input string tag);
        logic b;
        set_in(1'b1, w);
        @(negedge clk);                     // handshake edge T has passed
        set_in(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < cpb; j++) begin
                b = msb ? w[7-i] : w[i];
                check(tag, {27'd0, w_st}, {27'd0, 4'b1100, b});
                if (rnd) set_in(1'($urandom_range(0, 1)), 8'($urandom));
                @(negedge clk);
            end
        end
        set_in(1'b0, 8'h00);
        check({tag, "_done"}, {27'd0, w_st}, {27'd0, c_done});
        @(negedge clk);
        check({tag, "_idle"}, {27'd0, w_st}, {27'd0, c_idle});
    endtask

    initial begin
        int   spacing;
        logic [7:0] wv;
        n_checks    = 0;
        n_errors    = 0;
        cur         = 1'b0;
        clr_a       = 1'b1;
        clr_b       = 1'b1;
        ifa.valid   = 1'b0;
        ifa.data_in = 8'h00;
        ifb.valid   = 1'b0;
        ifb.data_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_a", {27'd0, w_st_a}, {27'd0, c_idle});
        check("rst_b", {27'd0, w_st_b}, {27'd0, c_idle});
        clr_a = 1'b0;
        clr_b = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hold_a", {27'd0, w_st_a}, {27'd0, c_idle});

        // Basic MSB-first frames, CPB=1
        cur = 1'b0;
        frame(8'hA5, 1, 1'b1, 1'b0, "a5_msb");
        frame(8'h96, 1, 1'b1, 1'b0, "96_msb");
        frame(8'h5B, 1, 1'b1, 1'b1, "rnd_a");

        // LSB-first, CPB=3
        cur = 1'b1;
        frame(8'h01, 3, 1'b0, 1'b0, "01_lsb3");
        frame(8'hC3, 3, 1'b0, 1'b1, "rnd_b");

        // Back-to-back with valid held high: FF then 00
        cur = 1'b0;
        spacing = 0;
        set_in(1'b1, 8'hFF);
        @(negedge clk);
        set_in(1'b1, 8'h00);
        for (int k = 0; k < 40; k++) begin
            if (k < 8) check("ff_bit", {27'd0, w_st}, {27'd0, 5'b11001});
            if (w_st[2]) begin
                spacing = k + 1;
                break;
            end
            @(negedge clk);
        end
        check("spacing", spacing, 32'd10);
        @(negedge clk);
        set_in(1'b0, 8'h00);
        check("second_start", {27'd0, w_st}, {27'd0, 5'b11000});
        wait_ready();

        // Reset during bit 4, then a frame on the first edge after release
        @(negedge clk);
        wv = 8'hF0;
        set_in(1'b1, wv);
        @(negedge clk);
        set_in(1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            check("pre_clr", {27'd0, w_st}, {27'd0, 4'b1100, wv[7-k]});
            @(negedge clk);
        end
        check("bit4", {27'd0, w_st}, {27'd0, 4'b1100, wv[3]});
        clr_a = 1'b1;
        #1;
        check("clr_async", {27'd0, w_st}, {27'd0, c_idle});
        @(negedge clk);
        check("clr_held", {27'd0, w_st}, {27'd0, c_idle});
        clr_a = 1'b0;
        frame(8'h3C, 1, 1'b1, 1'b0, "3c_after_clr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ser_tx_nb
`default_nettype wire
